// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared control bundle, opcodes and operand-use helpers
package core_pkg;

    typedef struct packed {
        logic       Branch;
        logic       MemRead;
        logic       MemtoReg;
        logic       MemWrite;
        logic       RegWrite;
        logic       ALUSrc;
        logic [3:0] ALUOp;
        logic [1:0] AuipcLui;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // U-type instructions carry immediate bits where rs1 would sit
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode != OP_LUI) && (opcode != OP_AUIPC);
    endfunction

    // Only R, S and B formats read a second source register
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detector
module hazard_detect
    import core_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [6:0]        id_opcode,
    output logic              load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // A load in EX conflicts with any real source operand of the ID instruction; x0 never conflicts
    always_comb begin
        rs1_hit  = (ex_rd == id_rs1) && uses_rs1(id_opcode);
        rs2_hit  = (ex_rd == id_rs2) && uses_rs2(id_opcode);
        load_use = ex_valid && ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use stall, flush and bubble counter
module id_ex_pipe
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  ctrl_t             id_ctrl,
    input  logic [6:0]        id_opcode,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              HZRDcontrol,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              ex_valid,
    output ctrl_t             ex_ctrl,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic load_use;
    logic bubble;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl.MemRead),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_opcode  (id_opcode),
        .load_use   (load_use)
    );

    // A flushed ID instruction is killed, so its load-use request is irrelevant
    assign bubble = flush || load_use;

    // ID/EX register: stall holds, bubble zeroes control locally, otherwise capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_NOP;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            bubble_cnt  <= '0;
        end else if (mem_stall) begin
            ex_valid    <= ex_valid;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_NOP;
            if (bubble_cnt != {CNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else begin
            ex_valid    <= 1'b1;
            ex_ctrl     <= id_ctrl;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7b5 <= id_funct7b5;
        end
    end

    // Front-end enables and decoder bubble request, same priority as the register update
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        HZRDcontrol = 1'b0;
        if (mem_stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (flush) begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
        end else if (load_use) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            HZRDcontrol = 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed self-checking bench for id_ex_pipe
module tb_id_ex_pipe;
    import core_pkg::*;

    localparam ctrl_t C_R   = '{Branch:1'b0, MemRead:1'b0, MemtoReg:1'b0, MemWrite:1'b0,
                                RegWrite:1'b1, ALUSrc:1'b0, ALUOp:4'b0010, AuipcLui:2'b00};
    localparam ctrl_t C_LW  = '{Branch:1'b0, MemRead:1'b1, MemtoReg:1'b1, MemWrite:1'b0,
                                RegWrite:1'b1, ALUSrc:1'b1, ALUOp:4'b0000, AuipcLui:2'b00};
    localparam ctrl_t C_SW  = '{Branch:1'b0, MemRead:1'b0, MemtoReg:1'b0, MemWrite:1'b1,
                                RegWrite:1'b0, ALUSrc:1'b1, ALUOp:4'b0000, AuipcLui:2'b00};
    localparam ctrl_t C_LUI = '{Branch:1'b0, MemRead:1'b0, MemtoReg:1'b0, MemWrite:1'b0,
                                RegWrite:1'b1, ALUSrc:1'b1, ALUOp:4'b0000, AuipcLui:2'b10};
    localparam ctrl_t C_I   = '{Branch:1'b0, MemRead:1'b0, MemtoReg:1'b0, MemWrite:1'b0,
                                RegWrite:1'b1, ALUSrc:1'b1, ALUOp:4'b0011, AuipcLui:2'b00};

    logic        CLK = 1'b0;
    logic        RST, rst2, flush, flush2, mem_stall;
    ctrl_t       id_ctrl;
    logic [6:0]  id_opcode;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;

    logic        HZRDcontrol, PCWrite, IFIDWrite, ex_valid, ex_funct7b5;
    ctrl_t       ex_ctrl;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [15:0] bubble_cnt;

    logic        s_hz, s_pcw, s_ifw, s_valid, s_f7;
    ctrl_t       s_ctrl;
    logic [31:0] s_pc, s_d1, s_d2, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_f3;
    logic [1:0]  s_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] hold_pc;
    logic [1:0]  sat_exp;

    always #5 CLK = ~CLK;

    id_ex_pipe dut (
        .CLK(CLK), .RST(RST), .id_ctrl(id_ctrl), .id_opcode(id_opcode), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .flush(flush), .mem_stall(mem_stall),
        .HZRDcontrol(HZRDcontrol), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(rst2), .id_ctrl(id_ctrl), .id_opcode(id_opcode), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .flush(flush2), .mem_stall(1'b0),
        .HZRDcontrol(s_hz), .PCWrite(s_pcw), .IFIDWrite(s_ifw),
        .ex_valid(s_valid), .ex_ctrl(s_ctrl), .ex_pc(s_pc), .ex_rs1_data(s_d1),
        .ex_rs2_data(s_d2), .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2),
        .ex_rd(s_rd), .ex_funct3(s_f3), .ex_funct7b5(s_f7),
        .bubble_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input ctrl_t c, input logic [6:0] op, input logic [31:0] pc,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        id_ctrl     = c;
        id_opcode   = op;
        id_pc       = pc;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        id_rs1_data = pc + 32'h11;
        id_rs2_data = pc + 32'h22;
        id_imm      = pc + 32'h33;
        id_funct3   = pc[4:2];
        id_funct7b5 = pc[5];
    endtask

    task automatic chk_fe(input string tag, input logic hz, input logic pcw, input logic ifw);
        chk({tag, ".HZRDcontrol"}, 64'(HZRDcontrol), 64'(hz));
        chk({tag, ".PCWrite"},     64'(PCWrite),     64'(pcw));
        chk({tag, ".IFIDWrite"},   64'(IFIDWrite),   64'(ifw));
    endtask

    initial begin
        RST = 1'b1; rst2 = 1'b1; flush = 1'b0; flush2 = 1'b0; mem_stall = 1'b0;
        set_id(ctrl_t'(12'($urandom)), 7'($urandom), $urandom,
               5'($urandom), 5'($urandom), 5'($urandom));

        // reset with random ID contents
        step();
        set_id(ctrl_t'(12'($urandom)), 7'($urandom), $urandom,
               5'($urandom), 5'($urandom), 5'($urandom));
        step();
        chk("rst.ex_valid", 64'(ex_valid), 64'(0));
        chk("rst.ex_ctrl", 64'(ex_ctrl), 64'(0));
        chk("rst.bubble_cnt", 64'(bubble_cnt), 64'(0));
        chk("rst.ex_pc", 64'(ex_pc), 64'(0));
        chk_fe("rst", 1'b0, 1'b1, 1'b1);
        RST = 1'b0;

        // capture add x3,x1,x2
        set_id(C_R, OP_R, 32'h100, 5'd1, 5'd2, 5'd3);
        step();
        chk("cap.ex_rd", 64'(ex_rd), 64'(3));
        chk("cap.RegWrite", 64'(ex_ctrl.RegWrite), 64'(1));
        chk("cap.ex_ctrl", 64'(ex_ctrl), 64'(C_R));
        chk("cap.ex_pc", 64'(ex_pc), 64'h100);
        chk("cap.ex_valid", 64'(ex_valid), 64'(1));
        chk("cap.ex_rs1_data", 64'(ex_rs1_data), 64'h111);
        chk("cap.ex_imm", 64'(ex_imm), 64'h133);

        // lw x5 then add x6,x5,x7
        set_id(C_LW, OP_LOAD, 32'h104, 5'd2, 5'd0, 5'd5);
        step();
        set_id(C_R, OP_R, 32'h108, 5'd5, 5'd7, 5'd6);
        #1;
        chk_fe("lu", 1'b1, 1'b0, 1'b0);
        step();
        chk("lu.ex_valid", 64'(ex_valid), 64'(0));
        chk("lu.ex_ctrl", 64'(ex_ctrl), 64'(0));
        chk("lu.bubble_cnt", 64'(bubble_cnt), 64'(1));
        chk_fe("lu.after", 1'b0, 1'b1, 1'b1);
        step();
        chk("lu.cap.ex_rd", 64'(ex_rd), 64'(6));
        chk("lu.cap.ex_valid", 64'(ex_valid), 64'(1));
        chk("lu.cap.ex_pc", 64'(ex_pc), 64'h108);

        // lw x8 then sw x8 via rs2
        set_id(C_LW, OP_LOAD, 32'h10c, 5'd2, 5'd0, 5'd8);
        step();
        set_id(C_SW, OP_S, 32'h110, 5'd2, 5'd8, 5'd4);
        #1;
        chk_fe("lu2", 1'b1, 1'b0, 1'b0);
        step();
        chk("lu2.bubble_cnt", 64'(bubble_cnt), 64'(2));
        step();
        chk("lu2.cap.ex_ctrl", 64'(ex_ctrl), 64'(C_SW));

        // no false hazard: lw x0 then add x6,x0,x1
        set_id(C_LW, OP_LOAD, 32'h114, 5'd2, 5'd0, 5'd0);
        step();
        set_id(C_R, OP_R, 32'h118, 5'd0, 5'd1, 5'd6);
        #1;
        chk_fe("nf.x0", 1'b0, 1'b1, 1'b1);
        step();
        chk("nf.x0.ex_valid", 64'(ex_valid), 64'(1));
        // lw x5 then lui x5 with rs fields aliasing x5
        set_id(C_LW, OP_LOAD, 32'h11c, 5'd2, 5'd0, 5'd5);
        step();
        set_id(C_LUI, OP_LUI, 32'h120, 5'd5, 5'd5, 5'd5);
        #1;
        chk_fe("nf.lui", 1'b0, 1'b1, 1'b1);
        step();
        chk("nf.lui.ex_ctrl", 64'(ex_ctrl), 64'(C_LUI));
        // lw x5 then addi with rs2 field aliasing x5
        set_id(C_LW, OP_LOAD, 32'h124, 5'd2, 5'd0, 5'd5);
        step();
        set_id(C_I, OP_I, 32'h128, 5'd1, 5'd5, 5'd9);
        #1;
        chk_fe("nf.addi", 1'b0, 1'b1, 1'b1);
        step();
        chk("nf.bubble_cnt", 64'(bubble_cnt), 64'(2));

        // flush in same cycle as load-use
        set_id(C_LW, OP_LOAD, 32'h12c, 5'd2, 5'd0, 5'd5);
        step();
        set_id(C_R, OP_R, 32'h130, 5'd5, 5'd1, 5'd6);
        flush = 1'b1;
        #1;
        chk_fe("fl", 1'b0, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        chk("fl.ex_valid", 64'(ex_valid), 64'(0));
        chk("fl.ex_ctrl", 64'(ex_ctrl), 64'(0));
        chk("fl.bubble_cnt", 64'(bubble_cnt), 64'(3));

        // mem_stall for 3 cycles
        set_id(C_R, OP_R, 32'h200, 5'd1, 5'd2, 5'd3);
        step();
        hold_pc = 32'h200;
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(C_LW, OP_LOAD, 32'h300 + 32'(i * 4), 5'd4, 5'd0, 5'd9);
            #1;
            chk_fe("ms", 1'b0, 1'b0, 1'b0);
            step();
            chk("ms.ex_pc", 64'(ex_pc), 64'(hold_pc));
            chk("ms.ex_rd", 64'(ex_rd), 64'(3));
            chk("ms.ex_ctrl", 64'(ex_ctrl), 64'(C_R));
            chk("ms.ex_valid", 64'(ex_valid), 64'(1));
        end
        chk("ms.bubble_cnt", 64'(bubble_cnt), 64'(3));
        mem_stall = 1'b0;
        step();
        chk("ms.rel.ex_pc", 64'(ex_pc), 64'h308);
        chk("ms.rel.ex_ctrl", 64'(ex_ctrl), 64'(C_LW));

        // stall beats pending load-use, then reset mid-stall clears everything
        set_id(C_R, OP_R, 32'h30c, 5'd9, 5'd1, 5'd10);
        mem_stall = 1'b1;
        #1;
        chk_fe("ms.lu", 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        mem_stall = 1'b0;
        chk("rst2.ex_valid", 64'(ex_valid), 64'(0));
        chk("rst2.ex_ctrl", 64'(ex_ctrl), 64'(0));
        chk("rst2.bubble_cnt", 64'(bubble_cnt), 64'(0));
        #1;
        chk_fe("rst2", 1'b0, 1'b1, 1'b1);

        // saturation with a 2-bit counter
        set_id(CTRL_NOP, OP_I, 32'h400, 5'd0, 5'd0, 5'd0);
        step();
        rst2 = 1'b0;
        chk("sat.init", 64'(s_cnt), 64'(0));
        flush2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            sat_exp = (i >= 2) ? 2'd3 : 2'(i + 1);
            chk("sat.cnt", 64'(s_cnt), 64'(sat_exp));
            chk("sat.valid", 64'(s_valid), 64'(0));
        end
        flush2 = 1'b0;
        step();
        chk("sat.hold", 64'(s_cnt), 64'(3));
        chk("sat.cap", 64'(s_valid), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
